// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter: default operand width,
// shift-amount width and the controller state encoding.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int SHAMT_W       = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The controller counts as occupied from the first shift step through the
  // completion cycle.
  function automatic logic isBusyState(input state_e s);
    return (s == SHIFT) || (s == DONE);
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One combinational barrel-shifter stage: shifts data right by 2^step.
// Vacated upper bits take the fill bit. With RIGHT_SHIFT_ROTATE_EN defined,
// an extra rotate input makes bits leaving bit 0 re-enter at the top instead.
module right_shift_stage #(
  parameter int WIDTH      = shift_pkg::DEFAULT_WIDTH,
  parameter int SHAMT_BITS = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]      data_i,
  input  logic [SHAMT_BITS-1:0] step_i,
  input  logic                  fill_i,
`ifdef RIGHT_SHIFT_ROTATE_EN
  input  logic                  rotate_i,
`endif
  output logic [WIDTH-1:0]      data_o
);

  logic [SHAMT_BITS-1:0] stepAmount;
  logic [WIDTH-1:0]      upperWord;

  // Step values stay below SHAMT_BITS, so 2^step is at most WIDTH/2 and fits.
  assign stepAmount = {{(SHAMT_BITS-1){1'b0}}, 1'b1} << step_i;

  // The word placed above the data supplies the bits that slide in from the
  // top: replicated fill for shifts, the data itself for a rotate.
`ifdef RIGHT_SHIFT_ROTATE_EN
  assign upperWord = rotate_i ? data_i : {WIDTH{fill_i}};
`else
  assign upperWord = {WIDTH{fill_i}};
`endif

  assign data_o = WIDTH'({upperWord, data_i} >> stepAmount);

endmodule

// File: rtl/right_shift_seq.sv
// Sequential right shifter. An accepted start captures the operand and mode,
// then one stage per cycle applies bit 'step' of the shift amount, from the
// most significant bit down to bit 0, giving a fixed latency whatever the
// shift amount. Optional rotate mode: define RIGHT_SHIFT_ROTATE_EN.
module right_shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SHAMT_BITS = $clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      A,
  input  logic [SHAMT_BITS-1:0] shamt,
  input  logic                  arith,
`ifdef RIGHT_SHIFT_ROTATE_EN
  input  logic                  rotate,
`endif
  output logic [WIDTH-1:0]      shift,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [SHAMT_BITS-1:0] shamt_q, shamt_d;
  logic [SHAMT_BITS-1:0] step_q,  step_d;
  logic                  arith_q, arith_d;
`ifdef RIGHT_SHIFT_ROTATE_EN
  logic                  rotate_q, rotate_d;
`endif

  logic [WIDTH-1:0]      stageData;
  logic                  stageFill;

  // Arithmetic mode replicates the current sign bit; logical mode fills zeros.
  assign stageFill = arith_q & shift_q[WIDTH-1];

  right_shift_stage #(
    .WIDTH      (WIDTH),
    .SHAMT_BITS (SHAMT_BITS)
  ) u_stage (
    .data_i   (shift_q),
    .step_i   (step_q),
    .fill_i   (stageFill),
`ifdef RIGHT_SHIFT_ROTATE_EN
    .rotate_i (rotate_q),
`endif
    .data_o   (stageData)
  );

  // Next-state logic: capture on start in IDLE, one shift step per SHIFT
  // cycle, and a single completion cycle before returning to IDLE.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shamt_d  = shamt_q;
    step_d   = step_q;
    arith_d  = arith_q;
`ifdef RIGHT_SHIFT_ROTATE_EN
    rotate_d = rotate_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = A;
          shamt_d  = shamt;
          arith_d  = arith;
`ifdef RIGHT_SHIFT_ROTATE_EN
          rotate_d = rotate;
`endif
          step_d   = SHAMT_BITS'(SHAMT_BITS - 1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[step_q]) begin
          shift_d = stageData;
        end
        if (step_q == '0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears captured context.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      shamt_q  <= '0;
      step_q   <= '0;
      arith_q  <= 1'b0;
`ifdef RIGHT_SHIFT_ROTATE_EN
      rotate_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      shamt_q  <= shamt_d;
      step_q   <= step_d;
      arith_q  <= arith_d;
`ifdef RIGHT_SHIFT_ROTATE_EN
      rotate_q <= rotate_d;
`endif
    end
  end

  assign shift = shift_q;
  assign busy  = isBusyState(state_q);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench for right_shift_seq (WIDTH=32). Build with
// RIGHT_SHIFT_ROTATE_EN defined to exercise rotate mode.
module tb_right_shift_seq;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   shamt;
  logic             arith;
`ifdef RIGHT_SHIFT_ROTATE_EN
  logic             rotate;
`endif
  logic [WIDTH-1:0] shift;
  logic             busy;
  logic             done;

  int testsRun  = 0;
  int failCount = 0;
  int doneCount = 0;

  logic [WIDTH-1:0] expQ[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   sh;
    logic             ar;
    logic             ro;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[$];

  right_shift_seq #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .A       (A),
    .shamt   (shamt),
    .arith   (arith),
`ifdef RIGHT_SHIFT_ROTATE_EN
    .rotate  (rotate),
`endif
    .shift   (shift),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Count every cycle in which done is observed high.
  always @(negedge clock) begin
    if (done) doneCount++;
  end

  // Reference shifter used to derive expectations for the random vectors.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [SHW-1:0] sh,
                                             input logic ar);
    if (ar) return $signed(a) >>> sh;
    return a >> sh;
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits for done after the accept edge, checking result, latency, busy span.
  task automatic awaitDone(input string name);
    int seen;
    int busyCycles;
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] want;
    seen = -1;
    busyCycles = 0;
    got = '0;
    for (int e = 0; e < 20; e++) begin
      if (e > 0) @(negedge clock);
      if (busy) busyCycles++;
      if (done) begin
        seen = e + 1;
        got = shift;
        break;
      end
    end
    want = (expQ.size() > 0) ? expQ.pop_front() : '0;
    if (seen < 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL %s timeout: got no done, expected done within 20 cycles", name);
    end else begin
      checkOutput({name, " result"}, got, want);
      checkOutput({name, " latency"}, 32'(seen), 32'(SHW + 1));
      checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(SHW + 1));
      @(negedge clock);
      checkOutput({name, " hold"}, shift, want);
      checkOutput({name, " idle"}, {31'b0, busy | done}, 32'd0);
    end
  endtask

  // Drives one operation, then scrambles the inputs while it is in flight.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    A = v.a;
    shamt = v.sh;
    arith = v.ar;
`ifdef RIGHT_SHIFT_ROTATE_EN
    rotate = v.ro;
`endif
    start = 1'b1;
    expQ.push_back(v.exp);
    @(negedge clock);
    start = 1'b0;
    A = ~v.a;
    shamt = ~v.sh;
    arith = ~v.ar;
`ifdef RIGHT_SHIFT_ROTATE_EN
    rotate = ~v.ro;
`endif
    awaitDone(v.name);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [WIDTH-1:0] ra;
    logic [SHW-1:0]   rs;
    logic             rar;

    vecs.push_back('{32'h8000_0000, 5'd8,  1'b0, 1'b0, 32'h0080_0000, "msb lsr8"});
    vecs.push_back('{32'h8000_0000, 5'd8,  1'b1, 1'b0, 32'hFF80_0000, "msb asr8"});
    vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, "msb asr31"});
    vecs.push_back('{32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678, "shamt0"});
    vecs.push_back('{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0001, "ones lsr31"});
    vecs.push_back('{32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 32'h0000_0000, "pos asr31"});
    vecs.push_back('{32'hDEAD_BEEF, 5'd4,  1'b1, 1'b0, 32'hFDEA_DBEE, "neg asr4"});
`ifdef RIGHT_SHIFT_ROTATE_EN
    vecs.push_back('{32'h0000_00FF, 5'd8,  1'b1, 1'b1, 32'hFF00_0000, "rotate8"});
`else
    vecs.push_back('{32'h0000_00FF, 5'd8,  1'b0, 1'b0, 32'h0000_0000, "lsr8 low"});
`endif
    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rs  = SHW'($urandom_range(0, WIDTH - 1));
      rar = 1'($urandom_range(0, 1));
      vecs.push_back('{ra, rs, rar, 1'b0, model(ra, rs, rar), $sformatf("random%0d", i)});
    end

    // Reset state, then the first start is presented on the first edge.
    reset_n = 1'b0;
    start = 1'b0;
    A = '0;
    shamt = '0;
    arith = 1'b0;
`ifdef RIGHT_SHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    #12;
    checkOutput("reset shift", shift, 32'h0);
    checkOutput("reset busy/done", {30'b0, busy, done}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    A = 32'hA5A5_0000;
    shamt = 5'd16;
    arith = 1'b1;
    start = 1'b1;
    expQ.push_back(32'hFFFF_A5A5);
    @(negedge clock);
    start = 1'b0;
    awaitDone("first start");

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Starts while busy and during the done cycle must be ignored.
    base = doneCount;
    @(negedge clock);
    A = 32'h0F0F_0000;
    shamt = 5'd4;
    arith = 1'b0;
    start = 1'b1;
    expQ.push_back(32'h00F0_F000);
    @(negedge clock);
    for (int k = 1; k <= 5; k++) begin
      A = $urandom;
      shamt = SHW'($urandom_range(0, WIDTH - 1));
      @(negedge clock);
    end
    checkOutput("ignored starts done", {31'b0, done}, 32'd1);
    checkOutput("ignored starts result", shift, expQ.pop_front());
    @(negedge clock);
    checkOutput("start in done ignored", {31'b0, busy}, 32'd0);
    start = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("single done pulse", 32'(doneCount - base), 32'd1);

    // Reset in the third shift cycle aborts the operation.
    @(negedge clock);
    A = 32'h8000_0000;
    shamt = 5'd8;
    arith = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort shift", shift, 32'h0);
    checkOutput("abort busy/done", {30'b0, busy, done}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    base = doneCount;
    repeat (10) @(negedge clock);
    checkOutput("no done after abort", 32'(doneCount - base), 32'd0);
    applyStimulus('{32'h8000_0000, 5'd8, 1'b0, 1'b0, 32'h0080_0000, "after abort"});

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
